// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a host-triggered run through data init and each compute layer,
// with a watchdog on the wait states and a level-sensitive abort.
module layer_sequencer #(
    parameter int LAYER_NUM_WIDTH = 3,
    parameter int LAYER_COUNT     = 5,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       transmission_start,
    input  logic                       init_fm_data_done,
    input  logic                       weight_data_done,
    input  logic                       layer_ready,
    output logic                       init,
    output logic                       layer_start,
    output logic [LAYER_NUM_WIDTH-1:0] layer_num,
    output logic [1:0]                 layer_type,
    output logic [1:0]                 pre_layer_type,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       seq_error
);
    localparam int                         WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]            WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAYER_NUM_WIDTH-1:0] LAST_LAYER = LAYER_NUM_WIDTH'(LAYER_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_REQ, S_WAIT_DATA, S_LAYER_START, S_LAYER_RUN, S_DONE, S_ERROR
    } state_t;

    state_t                     state_q, state_d;
    logic                       ts_prev_q, fm_ok_q, wt_ok_q;
    logic [WD_W-1:0]            wd_q;
    logic [LAYER_NUM_WIDTH-1:0] num_q, num_d;
    logic [1:0]                 type_q, pre_type_q, pre_type_d;
    logic                       init_q, start_q, busy_q, done_q, error_q;
    logic                       wd_expired, abort;

    function automatic logic [1:0] decode_type(input logic [LAYER_NUM_WIDTH-1:0] n);
        logic [1:0] t;
        case (32'(n))
            1, 2:    t = 2'd1;
            3:       t = 2'd2;
            4:       t = 2'd3;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        pre_type_d = pre_type_q;
        wd_expired = (wd_q == WD_LAST);
        abort      = !transmission_start &&
                     (state_q inside {S_INIT_REQ, S_WAIT_DATA, S_LAYER_START, S_LAYER_RUN});
        // Abort keeps layer_num/pre_layer_type so the host can see where the run stopped.
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (transmission_start && !ts_prev_q) begin
                        state_d    = S_INIT_REQ;
                        num_d      = '0;
                        pre_type_d = 2'd0;
                    end
                end
                S_INIT_REQ: state_d = S_WAIT_DATA;
                S_WAIT_DATA: begin
                    if (fm_ok_q && wt_ok_q) begin
                        state_d    = S_LAYER_START;
                        num_d      = LAYER_NUM_WIDTH'(1);
                        pre_type_d = 2'd0;
                    end else if (wd_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_LAYER_START: state_d = S_LAYER_RUN;
                S_LAYER_RUN: begin
                    if (layer_ready) begin
                        pre_type_d = type_q;
                        if (num_q == LAST_LAYER) begin
                            state_d = S_DONE;
                        end else begin
                            num_d   = num_q + LAYER_NUM_WIDTH'(1);
                            state_d = S_LAYER_START;
                        end
                    end else if (wd_expired) begin
                        state_d = S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (!transmission_start) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ts_prev_q  <= 1'b0;
            fm_ok_q    <= 1'b0;
            wt_ok_q    <= 1'b0;
            wd_q       <= '0;
            num_q      <= '0;
            type_q     <= 2'd0;
            pre_type_q <= 2'd0;
            init_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_prev_q  <= transmission_start;
            num_q      <= num_d;
            type_q     <= decode_type(num_d);
            pre_type_q <= pre_type_d;
            if (state_d == S_INIT_REQ) begin
                fm_ok_q <= 1'b0;
                wt_ok_q <= 1'b0;
            end else if (state_q == S_WAIT_DATA) begin
                fm_ok_q <= fm_ok_q | init_fm_data_done;
                wt_ok_q <= wt_ok_q | weight_data_done;
            end
            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (state_q inside {S_WAIT_DATA, S_LAYER_RUN}) begin
                wd_q <= wd_q + WD_W'(1);
            end
            // Outputs follow the next state so they line up with state_q.
            init_q  <= (state_d == S_INIT_REQ);
            start_q <= (state_d == S_LAYER_START);
            busy_q  <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERROR);
        end
    end

    assign init           = init_q;
    assign layer_start    = start_q;
    assign layer_num      = num_q;
    assign layer_type     = type_q;
    assign pre_layer_type = pre_type_q;
    assign busy           = busy_q;
    assign seq_done       = done_q;
    assign seq_error      = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed and randomized runs checked against a cycle timeline
// derived from when the done/ready inputs arrive.
module tb_layer_sequencer;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, ts, fm, wt, rdy;
    logic        init, layer_start, busy, seq_done, seq_error;
    logic [2:0]  layer_num;
    logic [1:0]  layer_type, pre_layer_type;
    logic [11:0] obs;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rdl [1:4];
    int          s [1:4];
    int          w, d;

    layer_sequencer #(
        .LAYER_NUM_WIDTH(3),
        .LAYER_COUNT(5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .transmission_start(ts),
        .init_fm_data_done(fm),
        .weight_data_done(wt),
        .layer_ready(rdy),
        .init(init),
        .layer_start(layer_start),
        .layer_num(layer_num),
        .layer_type(layer_type),
        .pre_layer_type(pre_layer_type),
        .busy(busy),
        .seq_done(seq_done),
        .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    assign obs = {init, layer_start, busy, seq_done, seq_error, layer_num, layer_type, pre_layer_type};

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    function automatic logic [1:0] lt_of(input int n);
        case (n)
            1, 2:    return 2'd1;
            3:       return 2'd2;
            4:       return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Timeline of one run: ts raised at t0, dones a/b cycles into WAIT_DATA, ready rdl[i] after start i.
    task automatic plan(input int t0, input int a, input int b);
        w    = t0 + 2;
        s[1] = w + ((a > b) ? a : b) + 2;
        for (int i = 1; i < 4; i++) s[i+1] = s[i] + rdl[i] + 1;
        d = s[4] + rdl[4] + 1;
    endtask

    task automatic do_run(input int a, input int b, input bit hold, input int limit);
        int   t0, last, li;
        logic rd, ls_e;
        t0 = cyc;
        plan(t0, a, b);
        last = (limit > 0) ? limit : d + 3;
        ts = 1'b1; fm = 1'b0; wt = 1'b0; rdy = 1'b0;
        while (cyc < last) begin
            step();
            li   = 0;
            ls_e = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                if (cyc >= s[i]) li = i;
                if (cyc == s[i]) ls_e = 1'b1;
            end
            chk("run", obs, {cyc == t0 + 1, ls_e, cyc < d, cyc >= d, 1'b0,
                             3'(li), lt_of(li), lt_of(cyc >= d ? 4 : li - 1)});
            fm = (cyc == w + a);
            wt = (cyc == w + b);
            rd = hold && (cyc >= s[1]);
            for (int i = 1; i <= 4; i++) if (cyc == s[i] + rdl[i]) rd = 1'b1;
            rdy = rd;
        end
    endtask

    task automatic finish_run();
        ts = 1'b0; fm = 1'b0; wt = 1'b0; rdy = 1'b0;
        repeat (2) begin
            step();
            chk("idle_hold", obs, {5'b0, 3'd4, 2'd3, 2'd3});
        end
    endtask

    task automatic rand_rdl();
        for (int i = 1; i <= 4; i++) rdl[i] = $urandom_range(6, 1);
    endtask

    initial begin
        rst = 1'b0; ts = 1'b0; fm = 1'b0; wt = 1'b0; rdy = 1'b0;
        repeat (3) begin
            step();
            chk("reset", obs, 12'd0);
        end
        rst = 1'b1;
        while (cyc < 10) begin
            step();
            chk("idle", obs, 12'd0);
        end

        // nominal: start at 10, fm at 15, wt at 20, ready 5 after each start
        for (int i = 1; i <= 4; i++) rdl[i] = 5;
        do_run(3, 8, 1'b0, 0);
        finish_run();

        // both dones in the first WAIT_DATA cycle
        rand_rdl();
        do_run(0, 0, 1'b0, 0);
        finish_run();

        repeat (6) begin
            rand_rdl();
            do_run($urandom_range(8, 0), $urandom_range(8, 0), 1'b0, 0);
            finish_run();
        end

        // layer_ready held high from the first layer_start onward
        for (int i = 1; i <= 4; i++) rdl[i] = 1;
        do_run($urandom_range(5, 0), $urandom_range(5, 0), 1'b1, 0);
        finish_run();

        // abort during LAYER_RUN of layer 2
        rdl[1] = $urandom_range(6, 1);
        rdl[2] = $urandom_range(6, 3);
        rdl[3] = 2;
        rdl[4] = 2;
        plan(cyc, 2, 1);
        do_run(2, 1, 1'b0, s[2] + 2);
        ts = 1'b0; rdy = 1'b0;
        repeat (3) begin
            step();
            chk("abort", obs, {5'b0, 3'd2, 2'd1, 2'd1});
        end

        // watchdog in LAYER_RUN: error 16 cycles after entering it
        rdl[1] = 1000;
        do_run(0, 0, 1'b0, cyc + 4 + TMO);
        repeat (3) begin
            step();
            chk("tmo_run", {9'b0, busy, seq_done, seq_error}, {9'b0, 3'b001});
        end
        ts = 1'b0;
        step();
        chk("tmo_run_clear", {9'b0, busy, seq_done, seq_error}, 12'd0);

        // watchdog in WAIT_DATA
        do_run(1000, 1000, 1'b0, cyc + 2 + TMO - 1);
        step();
        chk("tmo_wait", {9'b0, busy, seq_done, seq_error}, {9'b0, 3'b001});
        ts = 1'b0;
        step();
        chk("tmo_wait_clear", {9'b0, busy, seq_done, seq_error}, 12'd0);

        // reset during WAIT_DATA with fm already seen
        do_run(0, 1000, 1'b0, cyc + 5);
        rst = 1'b0; ts = 1'b0; fm = 1'b0; wt = 1'b0;
        step();
        chk("mid_reset", obs, 12'd0);
        rst = 1'b1;
        step();
        chk("post_reset", obs, 12'd0);
        do_run(1000, 2, 1'b0, cyc + 12);
        ts = 1'b0; wt = 1'b0;
        step();
        chk("wt_only_idle", obs, 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
